// File: rtl/pipemem_access.sv
// pipemem_access: MEM stage holding the EXE/MEM register and a stalling req/ack data-memory port
module pipemem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  output logic        mem_stall,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic [31:0] mmo,
  output logic [4:0]  mrn,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        mem_err
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t      state_q, state_d;
  logic        mwreg_q, mwreg_d, mm2reg_q, mm2reg_d, mwmem_q, mwmem_d, err_q, err_d;
  logic [31:0] malu_q, malu_d, mb_q, mb_d, mmo_q, mmo_d;
  logic [4:0]  mrn_q, mrn_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        access, timeout_hit, load_ack;
  always_comb begin
    access      = state_q == ACCESS;
    timeout_hit = access & (cnt_q == 8'(TIMEOUT - 1)) & ~dmem_ack;
    mem_stall   = access & ~dmem_ack & ~timeout_hit;
    load_ack    = access & dmem_ack & mm2reg_q;
    mwreg_d     = mem_stall ? mwreg_q : ewreg;
    mm2reg_d    = mem_stall ? mm2reg_q : em2reg;
    mwmem_d     = mem_stall ? mwmem_q : ewmem & ~em2reg;
    malu_d      = mem_stall ? malu_q : ealu;
    mb_d        = mem_stall ? mb_q : eb;
    mrn_d       = mem_stall ? mrn_q : ern;
    state_d     = mem_stall ? state_q : ((em2reg | ewmem) ? ACCESS : IDLE);
    cnt_d       = mem_stall ? cnt_q + 8'd1 : 8'd0;
    mmo_d       = load_ack ? dmem_rdata : mmo_q;
    err_d       = err_q | timeout_hit;
    mwreg       = mwreg_q & ~mem_stall & ~timeout_hit;
    mm2reg      = mm2reg_q;
    malu        = malu_q;
    mrn         = mrn_q;
    mmo         = load_ack ? dmem_rdata : mmo_q;
    dmem_req    = access;
    dmem_we     = access & mwmem_q;
    dmem_addr   = malu_q;
    dmem_wdata  = mb_q;
    mem_err     = err_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= 32'd0;
      mb_q     <= 32'd0;
      mrn_q    <= 5'd0;
      mmo_q    <= 32'd0;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mwmem_q  <= mwmem_d;
      malu_q   <= malu_d;
      mb_q     <= mb_d;
      mrn_q    <= mrn_d;
      mmo_q    <= mmo_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_pipemem_access.sv
// tb_pipemem_access: vector table, corner sequences and random traffic against a reference model
module tb_pipemem_access;
  localparam int T = 4;
  logic        clock = 1'b0, reset, ewreg, em2reg, ewmem, dmem_ack;
  logic [31:0] ealu, eb, dmem_rdata;
  logic [4:0]  ern;
  logic        mem_stall, mwreg, mm2reg, dmem_req, dmem_we, mem_err;
  logic [31:0] malu, mmo, dmem_addr, dmem_wdata;
  logic [4:0]  mrn;
  int          n_tests = 0, n_fail = 0;
  pipemem_access #(.TIMEOUT(T)) dut (
    .clock(clock), .reset(reset), .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
    .ealu(ealu), .eb(eb), .ern(ern), .mem_stall(mem_stall), .mwreg(mwreg),
    .mm2reg(mm2reg), .malu(malu), .mmo(mmo), .mrn(mrn), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .mem_err(mem_err)
  );
  always #5 clock = ~clock;
  logic        m_wreg, m_load, m_store, m_err;
  logic [31:0] m_alu, m_b, m_mmo;
  logic [4:0]  m_rn;
  int          m_wait;
  logic        e_busy, e_hit, e_stall;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic m_eval;
    e_busy  = m_load | m_store;
    e_hit   = e_busy && !dmem_ack && m_wait == T - 1;
    e_stall = e_busy && !dmem_ack && !e_hit;
  endtask
  task automatic m_check;
    m_eval;
    chk("mem_stall", 32'(mem_stall), 32'(e_stall));
    chk("dmem_req", 32'(dmem_req), 32'(e_busy));
    chk("dmem_we", 32'(dmem_we), 32'(e_busy & m_store));
    chk("dmem_addr", dmem_addr, m_alu);
    chk("dmem_wdata", dmem_wdata, m_b);
    chk("mwreg", 32'(mwreg), 32'(m_wreg & !e_stall & !e_hit));
    chk("mm2reg", 32'(mm2reg), 32'(m_load));
    chk("malu", malu, m_alu);
    chk("mrn", 32'(mrn), 32'(m_rn));
    chk("mmo", mmo, (m_load && dmem_ack) ? dmem_rdata : m_mmo);
    chk("mem_err", 32'(mem_err), 32'(m_err));
  endtask
  task automatic tick;
    m_eval;
    @(posedge clock);
    if (reset) begin
      {m_wreg, m_load, m_store, m_err} = '0;
      m_alu = 0; m_b = 0; m_mmo = 0; m_rn = 0; m_wait = 0;
    end else begin
      if (m_load && dmem_ack) m_mmo = dmem_rdata;
      if (e_hit) m_err = 1'b1;
      if (e_stall) m_wait++;
      else begin
        m_wreg = ewreg; m_load = em2reg; m_store = ewmem & ~em2reg;
        m_alu = ealu; m_b = eb; m_rn = ern; m_wait = 0;
      end
    end
    #1;
  endtask
  typedef struct {
    logic r, wr, m2, wm;
    logic [31:0] alu, b;
    logic [4:0] rn;
    logic ack;
    logic [31:0] rd;
    logic xs, xq, xw;
    logic [31:0] xmmo;
    logic [4:0] xrn;
    logic xe;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(input logic r, wr, m2, wm, input logic [31:0] alu, b, input logic [4:0] rn,
                             input logic ack, input logic [31:0] rd, input logic xs, xq, xw,
                             input logic [31:0] xmmo, input logic [4:0] xrn, input logic xe);
    v = '{r, wr, m2, wm, alu, b, rn, ack, rd, xs, xq, xw, xmmo, xrn, xe};
  endfunction
  initial begin
    tbl.push_back(v(0,1,1,0,'h100,0,5,0,0,             0,0,0,'h0,0,0));
    tbl.push_back(v(0,1,0,0,'h7,0,3,1,'hDEADBEEF,      0,1,1,'hDEADBEEF,5,0));
    tbl.push_back(v(0,0,0,1,'h40,'h12345678,0,0,0,     0,0,1,'hDEADBEEF,3,0));
    tbl.push_back(v(0,1,1,0,'h999,'h5,9,0,0,           1,1,0,'hDEADBEEF,0,0));
    tbl.push_back(v(0,1,0,1,'h888,'h6,4,0,'h55,        1,1,0,'hDEADBEEF,0,0));
    tbl.push_back(v(0,0,1,0,'h777,0,2,0,0,             1,1,0,'hDEADBEEF,0,0));
    tbl.push_back(v(0,1,1,0,'h200,0,7,1,'hABCD,        0,1,0,'hDEADBEEF,0,0));
    tbl.push_back(v(0,1,1,0,'h300,0,8,0,0,             1,1,0,'hDEADBEEF,7,0));
    tbl.push_back(v(0,1,1,0,'h300,0,8,1,'h11111111,    0,1,1,'h11111111,7,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 1,1,0,'h11111111,8,0));
    tbl.push_back(v(0,1,1,0,'h500,0,10,1,'h22222222,   0,1,1,'h22222222,8,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 1,1,0,'h22222222,10,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 1,1,0,'h22222222,10,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 1,1,0,'h22222222,10,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 0,1,0,'h22222222,10,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 0,0,0,'h22222222,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,1,'hFFFFFFFF,        0,0,0,'h22222222,0,1));
    tbl.push_back(v(0,1,1,0,'h600,0,11,0,0,            0,0,0,'h22222222,0,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 1,1,0,'h22222222,11,1));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                 1,1,0,'h22222222,11,1));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                 0,0,0,'h0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,1,'hFFFFFFFF,        0,0,0,'h0,0,0));
    reset = 1; {ewreg, em2reg, ewmem, dmem_ack} = '0; ealu = 0; eb = 0; ern = 0; dmem_rdata = 0;
    tick;
    tick;
    #1;
    chk("rst_stall", 32'(mem_stall), 0);
    chk("rst_req", 32'(dmem_req), 0);
    chk("rst_mwreg", 32'(mwreg), 0);
    chk("rst_malu", malu, 0);
    chk("rst_mmo", mmo, 0);
    chk("rst_mrn", 32'(mrn), 0);
    chk("rst_err", 32'(mem_err), 0);
    m_check;
    tick;
    foreach (tbl[i]) begin
      reset = tbl[i].r; ewreg = tbl[i].wr; em2reg = tbl[i].m2; ewmem = tbl[i].wm;
      ealu = tbl[i].alu; eb = tbl[i].b; ern = tbl[i].rn;
      dmem_ack = tbl[i].ack; dmem_rdata = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'(tbl[i].xs));
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(tbl[i].xq));
      chk($sformatf("v%0d_mwreg", i), 32'(mwreg), 32'(tbl[i].xw));
      chk($sformatf("v%0d_mmo", i), mmo, tbl[i].xmmo);
      chk($sformatf("v%0d_mrn", i), 32'(mrn), 32'(tbl[i].xrn));
      chk($sformatf("v%0d_err", i), 32'(mem_err), 32'(tbl[i].xe));
      if (i >= 3 && i <= 6) begin
        chk($sformatf("v%0d_we", i), 32'(dmem_we), 1);
        chk($sformatf("v%0d_addr", i), dmem_addr, 32'h40);
        chk($sformatf("v%0d_wdata", i), dmem_wdata, 32'h12345678);
      end
      m_check;
      tick;
    end
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      ewreg = 1'($urandom_range(0, 1));
      em2reg = ($urandom_range(0, 2) == 0);
      ewmem = ($urandom_range(0, 2) == 0);
      ealu = $urandom; eb = $urandom; ern = 5'($urandom_range(0, 31));
      dmem_ack = ($urandom_range(0, 2) == 0);
      dmem_rdata = $urandom;
      #1;
      m_check;
      tick;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
